// File: rtl/dm_wb_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back cache.
// The optional CACHE_STATS_EN build adds hit/miss counters in dm_wb_cache.
package dm_wb_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_e;

  localparam int META_W = 2;
  localparam int LINE_V = 1;
  localparam int LINE_D = 0;

  function automatic int off_w(input int bw);
    return $clog2(bw * 4);
  endfunction

  function automatic int idx_w(input int cap, input int bw);
    return $clog2(cap / (bw * 4));
  endfunction

  function automatic int tag_w(input int aw, input int cap, input int bw);
    return aw - off_w(bw) - idx_w(cap, bw);
  endfunction

  function automatic int word_w(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/dm_wb_cache_if.sv
// Pipeline-side and memory-side buses of the cache.
// slave = cache view, master = pipeline plus memory view.
interface dm_wb_cache_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] cache_req_addr;
  logic [31:0]       cache_req_data;
  logic              cache_req_wen;
  logic              cache_req_valid;
  logic [31:0]       cache_res_data;
  logic              cache_res_stall;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic              mem_req_wen;
  logic              mem_req_valid;
  logic [31:0]       mem_res_data;
  logic              mem_res_valid;

  modport slave (
    input  cache_req_addr, cache_req_data,
    input  cache_req_wen, cache_req_valid,
    output cache_res_data, cache_res_stall,
    output mem_req_addr, mem_req_data,
    output mem_req_wen, mem_req_valid,
    input  mem_res_data, mem_res_valid
  );

  modport master (
    output cache_req_addr, cache_req_data,
    output cache_req_wen, cache_req_valid,
    input  cache_res_data, cache_res_stall,
    input  mem_req_addr, mem_req_data,
    input  mem_req_wen, mem_req_valid,
    output mem_res_data, mem_res_valid
  );
endinterface

// File: rtl/dm_wb_cache_ctrl.sv
// Miss FSM and beat counter: sequences write-back and refill beats
// and emits the storage write strobes.
module dm_wb_cache_ctrl
  import dm_wb_cache_pkg::*;
#(
  parameter int BW = 1,
  parameter int WW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic          hit_i,
  input  logic          victim_dirty_i,
  input  logic          mem_res_valid_i,
  output state_e        state_o,
  output logic [WW-1:0] beat_o,
  output logic          mem_valid_o,
  output logic          mem_wen_o,
  output logic          refill_we_o,
  output logic          fill_done_o,
  output logic          wb_done_o
);

  state_e        state_q;
  logic [WW-1:0] beat_q;
  logic          mv_q;
  logic          mw_q;
  logic          last;

  assign last = (beat_q == WW'(BW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      mv_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i && !hit_i) begin
            beat_q <= '0;
            mv_q   <= 1'b1;
            mw_q   <= victim_dirty_i;
            state_q <= victim_dirty_i ? S_WB : S_REFILL;
          end
        end
        S_WB: begin
          if (mem_res_valid_i) begin
            if (last) begin
              state_q <= S_REFILL;
              beat_q  <= '0;
              mw_q    <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_REFILL: begin
          if (mem_res_valid_i) begin
            if (last) begin
              state_q <= S_IDLE;
              beat_q  <= '0;
              mv_q    <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          mv_q    <= 1'b0;
          mw_q    <= 1'b0;
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign beat_o      = beat_q;
  assign mem_valid_o = mv_q;
  assign mem_wen_o   = mw_q;
  assign refill_we_o = (state_q == S_REFILL) && mem_res_valid_i;
  assign fill_done_o = refill_we_o && last;
  assign wb_done_o   = (state_q == S_WB) && mem_res_valid_i && last;

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back write-allocate cache: storage and decode.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count ports.
module dm_wb_cache
  import dm_wb_cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CAPACITY_BYTES = 512,
  parameter int BLOCK_WORDS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  dm_wb_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF   = off_w(BLOCK_WORDS);
  localparam int IDX   = idx_w(CAPACITY_BYTES, BLOCK_WORDS);
  localparam int TAG   = tag_w(ADDR_W, CAPACITY_BYTES, BLOCK_WORDS);
  localparam int WW    = word_w(BLOCK_WORDS);
  localparam int LINES = 1 << IDX;
  localparam int SW    = IDX + $clog2(BLOCK_WORDS);

  logic [DATA_W-1:0] data_q [LINES*BLOCK_WORDS];
  logic [TAG-1:0]    tag_q  [LINES];
  logic [META_W-1:0] meta_q [LINES];

  state_e        state;
  logic [WW-1:0] beat;
  logic          mv, mw;
  logic          refill_we, fill_done, wb_done;
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag, sel_tag;
  logic [SW-1:0]  rd_sel, mem_sel;
  logic           idle, hit, victim_dirty, wr_hit;

  assign idx = bus.cache_req_addr[OFF+IDX-1:OFF];
  assign tag = bus.cache_req_addr[ADDR_W-1:OFF+IDX];

  if (BLOCK_WORDS > 1) begin : g_multi
    assign rd_sel  = {idx, bus.cache_req_addr[OFF-1:2]};
    assign mem_sel = {idx, beat};
  end else begin : g_single
    assign rd_sel  = idx;
    assign mem_sel = idx;
  end

  assign idle         = (state == S_IDLE);
  assign hit          = meta_q[idx][LINE_V] && (tag_q[idx] == tag);
  assign victim_dirty = meta_q[idx][LINE_V] && meta_q[idx][LINE_D];
  assign wr_hit       = idle && bus.cache_req_valid
                        && bus.cache_req_wen && hit;

  dm_wb_cache_ctrl #(
    .BW(BLOCK_WORDS),
    .WW(WW)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (bus.cache_req_valid),
    .hit_i          (hit),
    .victim_dirty_i (victim_dirty),
    .mem_res_valid_i(bus.mem_res_valid),
    .state_o        (state),
    .beat_o         (beat),
    .mem_valid_o    (mv),
    .mem_wen_o      (mw),
    .refill_we_o    (refill_we),
    .fill_done_o    (fill_done),
    .wb_done_o      (wb_done)
  );

  always_ff @(posedge clk) begin
    if (refill_we)   data_q[mem_sel] <= bus.mem_res_data;
    else if (wr_hit) data_q[rd_sel]  <= bus.cache_req_data;
    if (fill_done)   tag_q[idx]      <= tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) meta_q[i] <= '0;
    end else begin
      if (fill_done) begin
        meta_q[idx][LINE_V] <= 1'b1;
        meta_q[idx][LINE_D] <= 1'b0;
      end
      if (wb_done) meta_q[idx][LINE_D] <= 1'b0;
      if (wr_hit)  meta_q[idx][LINE_D] <= 1'b1;
    end
  end

  // write-back beats address the victim line, refill beats the request
  assign sel_tag = (state == S_WB) ? tag_q[idx] : tag;

  assign bus.mem_req_addr  = (ADDR_W'({sel_tag, idx}) << OFF)
                           | (ADDR_W'(beat) << 2);
  assign bus.mem_req_data  = data_q[mem_sel];
  assign bus.mem_req_wen   = mw;
  assign bus.mem_req_valid = mv;

  assign bus.cache_res_stall = rst || !idle
                             || (bus.cache_req_valid && !hit);
  assign bus.cache_res_data  = rst ? '0 : data_q[rd_sel];

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        retry_q;

  // the cycle after a refill completes the held miss; not a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q   <= '0;
      miss_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      retry_q <= fill_done;
      if (idle && bus.cache_req_valid && hit
          && !retry_q && hit_q != '1)
        hit_q <= hit_q + 1'b1;
      if (idle && bus.cache_req_valid && !hit && miss_q != '1)
        miss_q <= miss_q + 1'b1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dm_wb_cache.sv
// Self-checking bench: 512 B, 4-word lines, 2-cycle memory beats.
// Directed table, hand sequences and random traffic vs a flat-memory model.
module tb_dm_wb_cache;

  localparam int BW = 4;
  localparam int NL = 512 / (BW * 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_wb_cache_if #(.ADDR_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dm_wb_cache #(
    .ADDR_W(32),
    .DATA_W(32),
    .CAPACITY_BYTES(512),
    .BLOCK_WORDS(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    int          st;
    logic [31:0] rd;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] flat [logic [31:0]];
  beat_t       log_q[$];
  int          rcnt = 0;

  bit          mv [NL];
  bit          md [NL];
  logic [31:0] mt [NL];
  int          m_hits, m_miss;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] flat_rd(input logic [31:0] a);
    return flat.exists(a) ? flat[a] : dflt(a);
  endfunction

  // memory: each beat answered two cycles after it is presented
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_res_valid = 1'b0;
      rcnt = 0;
    end else if (bus.mem_res_valid) begin
      bus.mem_res_valid = 1'b0;
      rcnt = bus.mem_req_valid ? 1 : 0;
    end else if (bus.mem_req_valid) begin
      rcnt++;
      if (rcnt == 2) begin
        if (bus.mem_req_wen) begin
          mem[bus.mem_req_addr] = bus.mem_req_data;
        end else begin
          bus.mem_res_data = mem.exists(bus.mem_req_addr)
                           ? mem[bus.mem_req_addr]
                           : dflt(bus.mem_req_addr);
        end
        log_q.push_back('{bus.mem_req_wen, bus.mem_req_addr,
                          bus.mem_req_data});
        bus.mem_res_valid = 1'b1;
        rcnt = 0;
      end
    end else begin
      rcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      mv[i] = 0;
      md[i] = 0;
      mt[i] = 0;
    end
    flat.delete();
    mem.delete();
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cache_req_valid = 1'b0;
    bus.cache_req_wen = 1'b0;
    bus.cache_req_addr = '0;
    bus.cache_req_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.cache_res_stall), 32'd1);
    chk("rst_data", bus.cache_res_data, 32'd0);
    chk("rst_mvalid", 32'(bus.mem_req_valid), 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
`endif
    rst = 1'b0;
    model_clear();
    log_q.delete();
    @(posedge clk);
    #1;
  endtask

  // run one access; checks memory traffic against the model
  task automatic access(input logic [31:0] a, input logic w,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int stalls, output int exp_st,
                        output logic [31:0] exp_rd);
    int          idx;
    logic [31:0] tag, wa, ba;
    bit          hit, dirty;
    beat_t       exq[$];
    bit          ok;
    idx = int'((a >> 4) % NL);
    tag = a >> 9;
    wa  = a & ~32'h3;
    hit = mv[idx] && (mt[idx] == tag);
    dirty = mv[idx] && md[idx];
    exp_rd = flat_rd(wa);
    exp_st = hit ? 0 : (dirty ? 1 + 2 * 2 * BW : 1 + 2 * BW);
    if (!hit) begin
      if (dirty)
        for (int b = 0; b < BW; b++) begin
          ba = (mt[idx] << 9) | 32'(idx << 4) | 32'(b << 2);
          exq.push_back('{1'b1, ba, flat_rd(ba)});
        end
      for (int b = 0; b < BW; b++) begin
        ba = (tag << 9) | 32'(idx << 4) | 32'(b << 2);
        exq.push_back('{1'b0, ba, 32'd0});
      end
    end
    log_q.delete();
    bus.cache_req_addr = a;
    bus.cache_req_wen = w;
    bus.cache_req_data = d;
    bus.cache_req_valid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!bus.cache_res_stall) break;
      stalls++;
      if (stalls > 200) begin
        chk("timeout", 32'(stalls), 32'(exp_st));
        break;
      end
    end
    rd = bus.cache_res_data;
    @(posedge clk);
    #1;
    bus.cache_req_valid = 1'b0;
    ok = (log_q.size() == exq.size());
    if (ok)
      foreach (exq[i])
        if (log_q[i].w !== exq[i].w || log_q[i].a !== exq[i].a
            || (exq[i].w && log_q[i].d !== exq[i].d))
          ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL traffic @%h: got %0d beats expected %0d",
               a, log_q.size(), exq.size());
    end
    if (hit) m_hits++;
    else m_miss++;
    mv[idx] = 1;
    mt[idx] = tag;
    md[idx] = (hit ? md[idx] : 1'b0) | w;
    if (w) flat[wa] = d;
  endtask

  vec_t        tbl[10];
  logic [31:0] rd, erd, ra;
  int          st, est, n;
  logic        rw;

  initial begin
    bus.mem_res_data = '0;
    tbl[0] = '{32'h040, 1'b0, 32'h0, 9, dflt(32'h040)};
    tbl[1] = '{32'h044, 1'b1, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[2] = '{32'h044, 1'b0, 32'h0, 0, 32'hDEAD_BEEF};
    tbl[3] = '{32'h240, 1'b0, 32'h0, 17, dflt(32'h240)};
    tbl[4] = '{32'h044, 1'b0, 32'h0, 9, 32'hDEAD_BEEF};
    tbl[5] = '{32'h04C, 1'b0, 32'h0, 0, dflt(32'h04C)};
    tbl[6] = '{32'h100, 1'b1, 32'h1111_2222, 9, 32'h0};
    tbl[7] = '{32'h102, 1'b0, 32'h0, 0, 32'h1111_2222};
    tbl[8] = '{32'h500, 1'b0, 32'h0, 17, dflt(32'h500)};
    tbl[9] = '{32'h100, 1'b0, 32'h0, 9, 32'h1111_2222};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      access(tbl[i].a, tbl[i].w, tbl[i].d, rd, st, est, erd);
      chk($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].st));
      if (!tbl[i].w)
        chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
    end
`ifdef CACHE_STATS_EN
    chk("tbl_hits", hit_count, 32'd4);
    chk("tbl_miss", miss_count, 32'd6);
    access(32'h100, 1'b0, 32'h0, rd, st, est, erd);
    access(32'h104, 1'b0, 32'h0, rd, st, est, erd);
    access(32'h180, 1'b0, 32'h0, rd, st, est, erd);
    access(32'h184, 1'b1, 32'h5, rd, st, est, erd);
    chk("seq_hits", hit_count, 32'd7);
    chk("seq_miss", miss_count, 32'd7);
`endif

    // reset while the third refill beat is outstanding
    do_reset();
    bus.cache_req_addr = 32'h080;
    bus.cache_req_wen = 1'b0;
    bus.cache_req_valid = 1'b1;
    n = 0;
    while (log_q.size() < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_beats", 32'(log_q.size()), 32'd2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.cache_req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_mvalid", 32'(bus.mem_req_valid), 32'd0);
    chk("mid_stall", 32'(bus.cache_res_stall), 32'd1);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    access(32'h080, 1'b0, 32'h0, rd, st, est, erd);
    chk("mid_remiss", 32'(st), 32'd9);
    chk("mid_rd", rd, dflt(32'h080));

    for (int i = 0; i < 250; i++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4)
         | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rw = 1'($urandom_range(0, 1));
      access(ra, rw, $urandom, rd, st, est, erd);
      chk("rnd_stall", 32'(st), 32'(est));
      if (!rw) chk("rnd_rd", rd, erd);
    end
`ifdef CACHE_STATS_EN
    chk("rnd_hits", hit_count, 32'(m_hits));
    chk("rnd_miss", miss_count, 32'(m_miss));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
